// File: rtl/shift_ex_stage.sv
// EX-stage wrapper for MIPS shift instructions: decodes funct, drives a sign-filling barrel
// shifter, masks logical right shifts, and registers results into a valid/ready stage with a skid slot.

module shift_barrel (
    output logic [31:0] dout,
    input  logic [31:0] din,
    input  logic        sd,
    input  logic [4:0]  sn
);
    always_comb dout = sd ? 32'($signed(din) >>> sn) : (din << sn);
endmodule

module shift_ex_stage #(
    parameter int unsigned DW       = 32,
    parameter int unsigned RW       = 5,
    parameter bit          R0_GUARD = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_funct,
    input  logic [4:0]    in_shamt,
    input  logic [DW-1:0] in_rs,
    input  logic [DW-1:0] in_rt,
    input  logic [RW-1:0] in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic          out_illegal
);
    typedef struct packed {
        logic [DW-1:0] result;
        logic [RW-1:0] rd;
        logic          we;
        logic          ill;
    } ent_t;

    logic          sd, arith, var_sh, legal;
    logic [4:0]    sn;
    logic [DW-1:0] raw, mask;
    ent_t          new_ent;
    logic          unused_rs_hi;

    assign unused_rs_hi = ^in_rs[DW-1:5];

    always_comb begin
        sd     = in_funct[1];
        arith  = in_funct[0];
        var_sh = in_funct[2];
        legal  = in_funct inside {6'b000000, 6'b000010, 6'b000011,
                                  6'b000100, 6'b000110, 6'b000111};
        sn     = var_sh ? in_rs[4:0] : in_shamt;
    end

    shift_barrel u_shifter (
        .dout (raw),
        .din  (in_rt),
        .sd   (sd),
        .sn   (sn)
    );

    // Shifter always sign-fills right shifts; clear the vacated bits for SRL/SRLV.
    always_comb begin
        mask           = {DW{1'b1}} >> sn;
        new_ent        = '0;
        new_ent.rd     = in_rd;
        new_ent.ill    = ~legal;
        if (legal) begin
            new_ent.result = (sd & ~arith) ? (raw & mask) : raw;
        end
        new_ent.we     = legal & ~(R0_GUARD & (in_rd == '0));
    end

    ent_t m_q, m_d, s_q, s_d;
    logic m_valid_q, m_valid_d, s_valid_q, s_valid_d, rdy_q;
    logic accept, drain;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        accept    = in_valid & rdy_q & ~flush;
        drain     = m_valid_q & out_ready;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (drain) begin
            // S is only ever full while in_ready is low, so refill and accept are exclusive.
            if (s_valid_q) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_d = new_ent;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (m_valid_q) begin
                s_d       = new_ent;
                s_valid_d = 1'b1;
            end else begin
                m_d       = new_ent;
                m_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            rdy_q     <= 1'b1;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            rdy_q     <= ~s_valid_d;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = m_valid_q;
    assign out_result  = m_q.result;
    assign out_rd      = m_q.rd;
    assign out_we      = m_valid_q & m_q.we;
    assign out_illegal = m_valid_q & m_q.ill;
endmodule

// File: tb/tb_shift_ex_stage.sv
// Bench for shift_ex_stage: a queue-based reference model checked every cycle, plus
// hand-computed expectations for the directed scenarios.

module tb_shift_ex_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_funct = '0;
    logic [4:0]  in_shamt = '0;
    logic [31:0] in_rs = '0;
    logic [31:0] in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    shift_ex_stage #(.DW(32), .RW(5), .R0_GUARD(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct(in_funct), .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [4:0] rd);
        exp_t e;
        int unsigned n;
        e    = '0;
        e.rd = rd;
        n    = f[2] ? int'(rs % 32) : int'(sh);
        case (f)
            6'd0, 6'd4: e.res = rt << n;
            6'd2, 6'd6: e.res = rt >> n;
            6'd3, 6'd7: e.res = 32'($signed(rt) >>> n);
            default:    e.ill = 1'b1;
        endcase
        e.we = !e.ill && rd != 5'd0;
        return e;
    endfunction

    exp_t q[$];
    exp_t pend;
    logic acc = 1'b0, drn = 1'b0, fl = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", {out_valid, out_result, out_rd, out_we, out_illegal, in_ready},
                {1'b0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b1});
            acc = 1'b0; drn = 1'b0; fl = 1'b0;
        end else begin
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0)
                chk("payload", {out_result, out_rd, out_we, out_illegal}, q[0]);
            drn  = (q.size() != 0) && out_ready;
            acc  = in_valid && (q.size() < 2) && !flush;
            fl   = flush;
            pend = model(in_funct, in_shamt, in_rs, in_rt, in_rd);
        end
    end

    always @(posedge clk) begin
        if (rst) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (fl) q.delete();
            else if (acc) q.push_back(pend);
        end
    end

    always @(posedge rst) q.delete();

    task automatic setop(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] rd);
        in_funct = f; in_shamt = sh; in_rs = rs; in_rt = rt; in_rd = rd; in_valid = 1'b1;
    endtask

    task automatic op(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [4:0] rd);
        setop(f, sh, rs, rt, rd);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [5:0]  f;
        logic [4:0]  sh;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic        ordy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{6'd0, 5'd31, 32'h0, 32'h0000_0003, 5'd7, 1'b1};
        vecs[1] = '{6'd7, 5'd0, 32'h0000_001F, 32'h8000_0000, 5'd8, 1'b0};
        vecs[2] = '{6'd6, 5'd0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd9, 1'b0};
        vecs[3] = '{6'd4, 5'd0, 32'hFFFF_FFE8, 32'h0000_00AB, 5'd10, 1'b0};
        vecs[4] = '{6'd3, 5'd0, 32'h0, 32'h7FFF_0000, 5'd11, 1'b1};
        vecs[5] = '{6'd1, 5'd2, 32'h0, 32'h1234_5678, 5'd12, 1'b0};
        vecs[6] = '{6'd2, 5'd31, 32'h0, 32'hFFFF_FFFF, 5'd13, 1'b1};
        vecs[7] = '{6'd5, 5'd3, 32'h3, 32'h1, 5'd14, 1'b1};

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single ops through an always-ready sink
        op(6'd0, 5'd4, 32'h0, 32'h0000_00F1, 5'd3);
        @(negedge clk);
        chk("sll_result", out_result, 32'h0000_0F10);
        chk("sll_we", out_we, 1'b1);
        chk("sll_rd", out_rd, 5'd3);
        @(posedge clk); #1;
        op(6'd2, 5'd8, 32'h0, 32'h8000_0000, 5'd4);
        @(negedge clk); chk("srl_result", out_result, 32'h0080_0000);
        @(posedge clk); #1;
        op(6'd3, 5'd8, 32'h0, 32'h8000_0000, 5'd4);
        @(negedge clk); chk("sra_result", out_result, 32'hFF80_0000);
        @(posedge clk); #1;
        op(6'd6, 5'd0, 32'hFFFF_FFE1, 32'hFFFF_FFFF, 5'd4);
        @(negedge clk); chk("srlv_result", out_result, 32'h7FFF_FFFF);
        @(posedge clk); #1;
        op(6'd6, 5'd9, 32'h0000_0020, 32'h1234_5678, 5'd4);
        @(negedge clk); chk("srlv_sn0", out_result, 32'h1234_5678);
        @(posedge clk); #1;
        op(6'b100000, 5'd0, 32'h0, 32'h0000_FFFF, 5'd5);
        @(negedge clk);
        chk("illegal_flag", out_illegal, 1'b1);
        chk("illegal_result", out_result, 32'h0);
        chk("illegal_we", out_we, 1'b0);
        @(posedge clk); #1;
        op(6'd0, 5'd1, 32'h0, 32'h1, 5'd0);
        @(negedge clk); chk("r0_we", out_we, 1'b0);
        @(posedge clk); #1;

        // Backpressure: A in M, B in S, C held upstream
        out_ready = 1'b0;
        setop(6'd0, 5'd1, 32'h0, 32'h1, 5'd1);
        @(posedge clk); #1;
        setop(6'd2, 5'd4, 32'h0, 32'h0000_00F0, 5'd2);
        @(posedge clk); #1;
        setop(6'd3, 5'd31, 32'h0, 32'h8000_0000, 5'd3);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_head_A", out_result, 32'h0000_0002);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); chk("bp_then_B", out_result, 32'h0000_000F);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); chk("bp_then_C", out_result, 32'hFFFF_FFFF);
        @(posedge clk); #1;

        // Flush with M and S full; op presented in the flush cycle is dropped
        out_ready = 1'b0;
        op(6'd0, 5'd2, 32'h0, 32'h5, 5'd6);
        op(6'd0, 5'd3, 32'h0, 32'h5, 5'd6);
        setop(6'd0, 5'd4, 32'h0, 32'h5, 5'd6);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); chk("flush_no_ghost", out_valid, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset with M and S full
        op(6'd0, 5'd2, 32'h0, 32'h7, 5'd6);
        op(6'd0, 5'd3, 32'h0, 32'h7, 5'd6);
        #2 rst = 1'b1;
        #1 chk("async_reset_outs", {out_valid, out_result, out_rd, out_we, out_illegal},
               {1'b0, 32'h0, 5'h0, 1'b0, 1'b0});
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); chk("post_reset_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Directed vector table with varying sink readiness
        foreach (vecs[i]) begin
            setop(vecs[i].f, vecs[i].sh, vecs[i].rs, vecs[i].rt, vecs[i].rd);
            out_ready = vecs[i].ordy;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drained", out_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
